// File: rtl/hilo_unit.sv
// HI/LO register unit: MTHI/MTLO moves, single-cycle MUL writeback of an
// externally computed product, and a 32-step restoring signed divider.
module hilo_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [2:0]  op,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [63:0] P,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    localparam logic [2:0] OpMul  = 3'b001;
    localparam logic [2:0] OpDiv  = 3'b010;
    localparam logic [2:0] OpMthi = 3'b011;
    localparam logic [2:0] OpMtlo = 3'b100;

    typedef enum logic [1:0] {StIdle, StMulWb, StDivRun, StDivFix} state_e;

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;
    logic [31:0] cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] quo_q, quo_d;    // dividend magnitude shifting out, quotient shifting in
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;    // divisor magnitude
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        zdiv_q, zdiv_d;  // accepted DIV had a zero divisor

    logic        accept;
    logic [32:0] shifted;
    logic [33:0] diff;
    logic        ge;

    function automatic logic [31:0] mag(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    assign accept  = start && (state_q == StIdle);
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = {1'b0, shifted} - {2'b00, dvs_q};
    assign ge      = ~diff[33];

    // Next-state, datapath and writeback decisions
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zdiv_d  = zdiv_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    dz_d = 1'b0;
                    case (op)
                        OpMthi: begin
                            hi_d   = A;
                            done_d = 1'b1;
                        end
                        OpMtlo: begin
                            lo_d   = A;
                            done_d = 1'b1;
                        end
                        OpMul: begin
                            prod_d  = P;
                            state_d = StMulWb;
                        end
                        OpDiv: begin
                            qneg_d = A[31] ^ B[31];
                            rneg_d = A[31];
                            cnt_d  = 32'd0;
                            quo_d  = mag(A);
                            rem_d  = 32'd0;
                            dvs_d  = mag(B);
                            if (B == 32'd0) begin
                                zdiv_d  = 1'b1;
                                state_d = StDivFix;
                            end else begin
                                zdiv_d  = 1'b0;
                                state_d = StDivRun;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StMulWb: begin
                hi_d    = prod_q[63:32];
                lo_d    = prod_q[31:0];
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StDivRun: begin
                quo_d = {quo_q[30:0], ge};
                rem_d = ge ? diff[31:0] : shifted[31:0];
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == 32'd31) begin
                    state_d = StDivFix;
                end
            end
            StDivFix: begin
                if (zdiv_q) begin
                    dz_d = 1'b1;
                end else begin
                    lo_d = cond_neg(quo_q, qneg_q);
                    hi_d = cond_neg(rem_q, rneg_q);
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous clear taking priority over everything
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= StIdle;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= 32'd0;
            prod_q  <= 64'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            dvs_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zdiv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zdiv_q  <= zdiv_d;
        end
    end

    assign HI       = hi_q;
    assign LO       = lo_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: MUL, signed DIV, divide-by-zero, overflow,
// abort by clear, busy guard and back-to-back issue.
module tb_hilo_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [2:0]  op = 3'b000;
    logic        start = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [63:0] P = 64'd0;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_tests = 0;
    int n_fail  = 0;

    hilo_unit dut (
        .clock    (clock),
        .clear    (clear),
        .op       (op),
        .start    (start),
        .A        (A),
        .B        (B),
        .P        (P),
        .HI       (HI),
        .LO       (LO),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    // Advance one rising edge; inputs are driven and outputs sampled 1 unit after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation on the next edge, then drop start and scramble operands
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] p);
        op = o; A = a; B = b; P = p; start = 1'b1;
        tick();
        start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h0000_0003; P = 64'h1234_5678_9ABC_DEF0;
    endtask

    // Count edges after acceptance until done; bounded
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    int  cyc;
    logic seen_done;
    logic busy_ok;

    initial begin
        // Reset
        tick();
        tick();
        clear = 1'b0;
        chk("reset_hi", HI, 0);
        chk("reset_lo", LO, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_divz", div_zero, 0);

        // MUL
        issue(3'b001, 0, 0, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("mul_busy", busy, 1);
        chk("mul_nodone", done, 0);
        tick();
        chk("mul_hi", HI, 32'hFFFF_FFFF);
        chk("mul_lo", LO, 32'hFFFF_FFFA);
        chk("mul_done", done, 1);
        chk("mul_idle", busy, 0);
        tick();
        chk("mul_done_pulse", done, 0);

        // DIV -7 / 2, busy all the way through
        issue(3'b010, 32'hFFFF_FFF9, 32'd2, 0);
        busy_ok = 1'b1;
        cyc = 0;
        while (!done && cyc < 60) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        chk("div1_busy", busy_ok, 1);
        chk("div1_cycles", cyc, 33);
        chk("div1_lo", LO, 32'hFFFF_FFFD);
        chk("div1_hi", HI, 32'hFFFF_FFFF);
        chk("div1_idle", busy, 0);

        // Back-to-back: start accepted while done is high; 100 / 7
        issue(3'b010, 32'd100, 32'd7, 0);
        chk("b2b_busy", busy, 1);
        wait_done(cyc);
        chk("div2_cycles", cyc, 33);
        chk("div2_lo", LO, 32'd14);
        chk("div2_hi", HI, 32'd2);

        // 7 / -2 -> q=-3 r=1
        issue(3'b010, 32'd7, 32'hFFFF_FFFE, 0);
        wait_done(cyc);
        chk("div3_lo", LO, 32'hFFFF_FFFD);
        chk("div3_hi", HI, 32'd1);

        // -100 / -7 -> q=14 r=-2
        issue(3'b010, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0);
        wait_done(cyc);
        chk("div4_lo", LO, 32'd14);
        chk("div4_hi", HI, 32'hFFFF_FFFE);

        // Overflow
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        wait_done(cyc);
        chk("ovf_cycles", cyc, 33);
        chk("ovf_lo", LO, 32'h8000_0000);
        chk("ovf_hi", HI, 32'h0000_0000);
        chk("ovf_divz", div_zero, 0);
        tick();

        // Divide by zero with preloaded HI/LO
        issue(3'b011, 32'h11, 0, 0);
        chk("mthi_hi", HI, 32'h11);
        chk("mthi_done", done, 1);
        chk("mthi_busy", busy, 0);
        issue(3'b100, 32'h22, 0, 0);
        chk("mtlo_lo", LO, 32'h22);
        issue(3'b010, 32'd5, 32'd0, 0);
        chk("dz_busy", busy, 1);
        chk("dz_divz_early", div_zero, 0);
        tick();
        chk("dz_divz", div_zero, 1);
        chk("dz_done", done, 1);
        chk("dz_idle", busy, 0);
        chk("dz_hi", HI, 32'h11);
        chk("dz_lo", LO, 32'h22);

        // NOP clears div_zero, no done, no register change
        issue(3'b111, 32'h55, 0, 0);
        chk("nop_divz", div_zero, 0);
        chk("nop_done", done, 0);
        chk("nop_hi", HI, 32'h11);
        chk("nop_lo", LO, 32'h22);

        // Abort on the 10th DIV_RUN cycle
        issue(3'b010, 32'd100, 32'd7, 0);
        repeat (9) tick();
        chk("abort_prebusy", busy, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_hi", HI, 0);
        chk("abort_lo", LO, 0);
        seen_done = done;
        repeat (40) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        chk("abort_nodone", seen_done, 0);

        // Busy guard: MTHI strobed during DIV is ignored
        issue(3'b010, 32'd100, 32'd7, 0);
        op = 3'b011; A = 32'h1234; start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        chk("guard_hi", HI, 0);
        chk("guard_busy", busy, 1);
        wait_done(cyc);
        chk("guard_cycles", cyc, 30);
        chk("guard_lo", LO, 32'd14);
        chk("guard_div_hi", HI, 32'd2);
        tick();
        issue(3'b011, 32'h1234, 0, 0);
        chk("idle_mthi_hi", HI, 32'h0000_1234);
        chk("idle_mthi_done", done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
